// File: rtl/rate_limit_pkg.sv
// rate_limit_pkg
// Shared constants and helpers for the rate-limited round-robin scheduler.
//   DEF_CAP / DEF_RATE / DEF_PKT_SIZE : default bucket capacity, refill per
//                                       cycle and cost of one packet (tokens)
//   tok_width()                       : bucket counter width that can hold
//                                       CAP plus one refill before saturation
//   sat_add()                         : refill, deduct, then clamp to capacity
package rate_limit_pkg;

  localparam int unsigned DEF_CAP      = 10;
  localparam int unsigned DEF_RATE     = 1;
  localparam int unsigned DEF_PKT_SIZE = 3;

  // The intermediate sum can reach CAP+RATE before clamping, so size for that.
  function automatic int unsigned tok_width(input int unsigned cap,
                                            input int unsigned rate);
    return $clog2(cap + rate + 1);
  endfunction

  // Deduction is only ever requested when val >= dec, so the difference
  // never wraps; saturation is applied after both refill and deduction.
  function automatic int unsigned sat_add(input int unsigned val,
                                          input int unsigned inc,
                                          input int unsigned dec,
                                          input int unsigned cap);
    int unsigned sum;
    sum = val + inc - dec;
    return (sum > cap) ? cap : sum;
  endfunction

endpackage

// File: rtl/rate_limit_scheduler_bucket.sv
// token_bucket_counter
// One per-requester token bucket. Every cycle it gains RATE tokens, loses
// PKT_SIZE tokens when its requester is granted, and saturates at CAP.
//   clk      : clock, state updates on the rising edge
//   rst      : synchronous active-high reset, empties the bucket
//   consume  : the requester is being granted at this edge
//   tokens   : registered bucket level
//   eligible : bucket holds enough tokens for one packet
module token_bucket_counter
  import rate_limit_pkg::*;
#(
  parameter int unsigned CAP      = DEF_CAP,
  parameter int unsigned RATE     = DEF_RATE,
  parameter int unsigned PKT_SIZE = DEF_PKT_SIZE,
  parameter int unsigned TOKW     = tok_width(DEF_CAP, DEF_RATE)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            consume,
  output logic [TOKW-1:0] tokens,
  output logic            eligible
);

  logic [TOKW-1:0] r_tokens;
  logic [31:0]     w_dec;

  assign w_dec = consume ? PKT_SIZE : 32'd0;

  // Reset wins over any grant computed in the same cycle, so nothing is
  // deducted from a bucket that is being cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tokens <= '0;
    end else begin
      r_tokens <= TOKW'(sat_add(32'(r_tokens), RATE, w_dec, CAP));
    end
  end

  assign tokens   = r_tokens;
  assign eligible = (32'(r_tokens) >= PKT_SIZE);

endmodule

// File: rtl/rate_limit_scheduler.sv
// rate_limit_scheduler
// Shares one packet slot among N requesters. Each requester owns a token
// bucket; a round-robin arbiter grants at most one eligible requester per
// cycle, where eligible means requesting with at least PKT_SIZE tokens.
//   clk        : clock
//   rst        : synchronous active-high reset
//   req        : per-requester request level
//   gnt        : registered one-hot grant pulse
//   gnt_valid  : registered, high when any grant is issued
//   gnt_id     : registered index of the granted requester (0 when none)
//   throttled  : registered, requester asked but lacked tokens
//   tokens_o   : bucket levels, requester i at [i*TOKW +: TOKW]
module rate_limit_scheduler
  import rate_limit_pkg::*;
#(
  parameter int unsigned N        = 4,
  parameter int unsigned CAP      = DEF_CAP,
  parameter int unsigned RATE     = DEF_RATE,
  parameter int unsigned PKT_SIZE = DEF_PKT_SIZE,
  parameter int unsigned TOKW     = tok_width(CAP, RATE)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         gnt,
  output logic                 gnt_valid,
  output logic [$clog2(N)-1:0] gnt_id,
  output logic [N-1:0]         throttled,
  output logic [N*TOKW-1:0]    tokens_o
);

  localparam int unsigned PW = $clog2(N);

  if (PKT_SIZE > CAP || RATE < 1 || N < 2) begin : g_bad_params
    $error("rate_limit_scheduler: need PKT_SIZE <= CAP, RATE >= 1, N >= 2");
  end

  logic [PW-1:0]   r_ptr;
  logic [N-1:0]    r_gnt;
  logic            r_gnt_valid;
  logic [PW-1:0]   r_gnt_id;
  logic [N-1:0]    r_throttled;

  logic [N-1:0]    w_bucket_ok;
  logic [N-1:0]    w_elig;
  logic [2*N-1:0]  w_elig_dbl;
  logic            w_found;
  logic [PW-1:0]   w_sel;
  logic [PW-1:0]   w_ptr_next;
  logic [N-1:0]    w_gnt_next;
  logic [TOKW-1:0] w_tok [N];

  // One bucket per requester; the bucket only knows whether it was granted.
  for (genvar gi = 0; gi < N; gi++) begin : g_bucket
    token_bucket_counter #(
      .CAP      (CAP),
      .RATE     (RATE),
      .PKT_SIZE (PKT_SIZE),
      .TOKW     (TOKW)
    ) u_bucket (
      .clk      (clk),
      .rst      (rst),
      .consume  (w_gnt_next[gi]),
      .tokens   (w_tok[gi]),
      .eligible (w_bucket_ok[gi])
    );
    assign tokens_o[gi*TOKW +: TOKW] = w_tok[gi];
  end

  assign w_elig     = req & w_bucket_ok;
  assign w_elig_dbl = {w_elig, w_elig};

  // Round-robin pick: scanning the doubled vector from the pointer finds the
  // first eligible requester at or after ptr with wrap-around, without a
  // modulo on a variable index.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    for (int j = 0; j < 2 * N; j++) begin
      if (!w_found && (j >= int'(r_ptr)) && w_elig_dbl[j]) begin
        w_found = 1'b1;
        w_sel   = (j >= int'(N)) ? PW'(j - int'(N)) : PW'(j);
      end
    end
  end

  // Grant vector feeds both the buckets (deduction) and the output register.
  always_comb begin
    w_gnt_next = '0;
    w_ptr_next = r_ptr;
    if (w_found) begin
      w_gnt_next[w_sel] = 1'b1;
      w_ptr_next        = (32'(w_sel) == N - 1) ? '0 : w_sel + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr       <= '0;
      r_gnt       <= '0;
      r_gnt_valid <= 1'b0;
      r_gnt_id    <= '0;
      r_throttled <= '0;
    end else begin
      r_ptr       <= w_ptr_next;
      r_gnt       <= w_gnt_next;
      r_gnt_valid <= w_found;
      r_gnt_id    <= w_sel;
      r_throttled <= req & ~w_elig;
    end
  end

  assign gnt       = r_gnt;
  assign gnt_valid = r_gnt_valid;
  assign gnt_id    = r_gnt_id;
  assign throttled = r_throttled;

endmodule

// File: tb/tb_rate_limit_scheduler.sv
// tb_rate_limit_scheduler
// Scoreboard bench: each driven cycle pushes the expected registered outputs
// computed by a token-bucket / round-robin reference model; a monitor pops
// and compares one entry after every rising edge.
module tb_rate_limit_scheduler;

  localparam int N        = 4;
  localparam int CAP      = 10;
  localparam int RATE     = 1;
  localparam int PKT_SIZE = 3;
  localparam int TOKW     = $clog2(CAP + RATE + 1);

  typedef struct {
    logic [N-1:0]      gnt;
    logic              gntValid;
    logic [1:0]        gntId;
    logic [N-1:0]      throttled;
    logic [N*TOKW-1:0] tokens;
  } expT;

  logic              clk;
  logic              rst;
  logic [N-1:0]      req;
  logic [N-1:0]      gnt;
  logic              gntValid;
  logic [1:0]        gntId;
  logic [N-1:0]      throttled;
  logic [N*TOKW-1:0] tokensO;

  expT expQ[$];
  int  modelTok[N];
  int  modelPtr;
  int  checks;
  int  fails;

  rate_limit_scheduler #(
    .N        (N),
    .CAP      (CAP),
    .RATE     (RATE),
    .PKT_SIZE (PKT_SIZE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .gnt_valid (gntValid),
    .gnt_id    (gntId),
    .throttled (throttled),
    .tokens_o  (tokensO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain per-bucket arithmetic and a rotating search.
  task automatic modelStep(input logic [N-1:0] reqVal, input logic rstVal);
    expT e;
    int  win;
    int  t;
    e.gnt       = '0;
    e.gntValid  = 1'b0;
    e.gntId     = '0;
    e.throttled = '0;
    e.tokens    = '0;
    if (rstVal) begin
      for (int i = 0; i < N; i++) modelTok[i] = 0;
      modelPtr = 0;
    end else begin
      win = -1;
      for (int off = 0; off < N; off++) begin
        int cand;
        cand = (modelPtr + off) % N;
        if (win < 0 && reqVal[cand] && modelTok[cand] >= PKT_SIZE) win = cand;
      end
      for (int i = 0; i < N; i++)
        e.throttled[i] = reqVal[i] && (modelTok[i] < PKT_SIZE);
      if (win >= 0) begin
        e.gnt[win] = 1'b1;
        e.gntValid = 1'b1;
        e.gntId    = 2'(win);
        modelPtr   = (win + 1) % N;
      end
      for (int i = 0; i < N; i++) begin
        t = modelTok[i] + RATE - ((i == win) ? PKT_SIZE : 0);
        modelTok[i] = (t > CAP) ? CAP : t;
      end
    end
    for (int i = 0; i < N; i++) e.tokens[i*TOKW +: TOKW] = TOKW'(modelTok[i]);
    expQ.push_back(e);
  endtask

  task automatic applyStimulus(input logic [N-1:0] reqVal, input logic rstVal);
    @(negedge clk);
    req = reqVal;
    rst = rstVal;
    modelStep(reqVal, rstVal);
  endtask

  task automatic compareField(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput(input expT e);
    compareField("gnt",       32'(gnt),       32'(e.gnt));
    compareField("gnt_valid", 32'(gntValid),  32'(e.gntValid));
    compareField("gnt_id",    32'(gntId),     32'(e.gntId));
    compareField("throttled", 32'(throttled), 32'(e.throttled));
    compareField("tokens_o",  32'(tokensO),   32'(e.tokens));
  endtask

  // Monitor: outputs settle after the edge, so sample 1 time unit later.
  initial begin
    expT e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks   = 0;
    fails    = 0;
    modelPtr = 0;
    for (int i = 0; i < N; i++) modelTok[i] = 0;
    req = '0;
    rst = 1'b1;

    $display("[TB] idle fill and saturation");
    repeat (2) applyStimulus(4'b0000, 1'b1);
    repeat (12) applyStimulus(4'b0000, 1'b0);

    $display("[TB] single requester from reset release");
    applyStimulus(4'b0000, 1'b1);
    repeat (15) applyStimulus(4'b0001, 1'b0);

    $display("[TB] all requesters with full buckets, reset mid-stream");
    applyStimulus(4'b0000, 1'b1);
    repeat (11) applyStimulus(4'b0000, 1'b0);
    repeat (10) applyStimulus(4'b1111, 1'b0);
    applyStimulus(4'b1111, 1'b1);
    repeat (8) applyStimulus(4'b1111, 1'b0);

    $display("[TB] pointer at 1 with requester 1 short of tokens");
    applyStimulus(4'b0000, 1'b1);
    repeat (10) applyStimulus(4'b0010, 1'b0);
    applyStimulus(4'b0001, 1'b0);
    applyStimulus(4'b0011, 1'b0);
    applyStimulus(4'b0000, 1'b0);

    $display("[TB] randomized traffic");
    for (int c = 0; c < 400; c++) begin
      applyStimulus(4'($urandom()), ($urandom_range(0, 63) == 0));
    end

    @(negedge clk);
    compareField("scoreboard_drained", 32'(expQ.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
